// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - call debounce/latch and one-at-a-time scheduler for a four-floor car (SCHED_SWEEP_EN selects sweep scheduling)
module elevator_call_scheduler #(
    parameter int DB_CYCLES    = 50000,
    parameter int DWELL_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic [3:0] floor,
    output logic [3:0] target,
    output logic [3:0] pending,
    output logic       busy,
    output logic       door_open
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    localparam logic [23:0] DB_LAST    = 24'(DB_CYCLES - 1);
    localparam logic [23:0] DWELL_LOAD = 24'(DWELL_CYCLES);

    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [3:0]  r_db;
    logic [3:0]  r_db_d;
    logic [23:0] r_db_cnt [4];

    state_t      r_state;
    logic [3:0]  r_target;
    logic [3:0]  r_pending;
    logic        r_busy;
    logic        r_door_open;
    logic [23:0] r_dwell_cnt;

    logic [3:0]  w_rise;
    logic        w_floor_valid;
    logic [1:0]  w_fidx;
    logic [1:0]  w_sel_idx;
    logic [3:0]  w_sel;
    logic [3:0]  w_clr;
    logic [3:0]  w_here;

`ifdef SCHED_SWEEP_EN
    logic        r_dir;
    logic        w_dir_eff;
    logic        w_dir_new;
    logic        w_has_up;
    logic        w_has_dn;
    logic [1:0]  w_up_idx;
    logic [1:0]  w_dn_idx;
`endif

    // Two-flop synchronizer for the asynchronous buttons
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debouncer: accept a level only after DB_CYCLES consecutive differing cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db   <= '0;
            r_db_d <= '0;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
        end else begin
            r_db_d <= r_db;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_db[i]     <= r_sync2[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 24'd1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_rise        = r_db & ~r_db_d;
    assign w_floor_valid = (floor != 4'b0000) && ((floor & (floor - 4'd1)) == 4'b0000);
    assign w_here        = r_pending & floor;

    // Floor index and next-call selection
    always_comb begin
        w_fidx = 2'd0;
        case (floor)
            4'b0010: w_fidx = 2'd1;
            4'b0100: w_fidx = 2'd2;
            4'b1000: w_fidx = 2'd3;
            default: w_fidx = 2'd0;
        endcase
        w_sel_idx = 2'd0;
`ifdef SCHED_SWEEP_EN
        // The end floors force the sweep direction; otherwise keep going the same way
        w_dir_eff = floor[3] ? 1'b0 : (floor[0] ? 1'b1 : r_dir);
        w_has_up  = 1'b0;
        w_has_dn  = 1'b0;
        w_up_idx  = 2'd0;
        w_dn_idx  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_pending[i] && (2'(i) > w_fidx)) begin
                w_has_up = 1'b1;
                w_up_idx = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (r_pending[i] && (2'(i) < w_fidx)) begin
                w_has_dn = 1'b1;
                w_dn_idx = 2'(i);
            end
        end
        if (w_dir_eff) begin
            w_dir_new = w_has_up;
            w_sel_idx = w_has_up ? w_up_idx : w_dn_idx;
        end else begin
            w_dir_new = !w_has_dn;
            w_sel_idx = w_has_dn ? w_dn_idx : w_up_idx;
        end
`else
        for (int i = 3; i >= 0; i--) begin
            if (r_pending[i]) w_sel_idx = 2'(i);
        end
`endif
        w_sel = 4'b0001 << w_sel_idx;
    end

    // Pending bits retired this cycle; nothing retires while the floor is ambiguous
    always_comb begin
        w_clr = 4'b0000;
        if (w_floor_valid) begin
            case (r_state)
                ST_IDLE:  w_clr = w_here;
                ST_SERVE: w_clr = (floor == r_target) ? r_target : 4'b0000;
                ST_DWELL: w_clr = w_here;
                default:  w_clr = 4'b0000;
            endcase
        end
    end

    // Scheduler FSM with call latching, target, dwell timer and registered status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_target    <= 4'b0001;
            r_pending   <= 4'b0000;
            r_busy      <= 1'b0;
            r_door_open <= 1'b0;
            r_dwell_cnt <= '0;
`ifdef SCHED_SWEEP_EN
            r_dir       <= 1'b1;
`endif
        end else begin
            // A clear in the same cycle as a new press on that bit wins
            r_pending <= (r_pending | w_rise) & ~w_clr;
            if (w_floor_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_here != 4'b0000) begin
                            r_state     <= ST_DWELL;
                            r_dwell_cnt <= DWELL_LOAD;
                            r_busy      <= 1'b1;
                            r_door_open <= 1'b1;
                        end else if (r_pending != 4'b0000) begin
                            r_state  <= ST_SERVE;
                            r_target <= w_sel;
                            r_busy   <= 1'b1;
`ifdef SCHED_SWEEP_EN
                            r_dir    <= w_dir_new;
`endif
                        end else begin
                            r_target <= floor;
                        end
                    end
                    ST_SERVE: begin
                        if (floor == r_target) begin
                            r_state     <= ST_DWELL;
                            r_dwell_cnt <= DWELL_LOAD;
                            r_door_open <= 1'b1;
                        end
                    end
                    ST_DWELL: begin
                        if (w_here != 4'b0000) begin
                            r_dwell_cnt <= DWELL_LOAD;
                        end else if (r_dwell_cnt == 24'd0) begin
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                            r_door_open <= 1'b0;
                        end else begin
                            r_dwell_cnt <= r_dwell_cnt - 24'd1;
                        end
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_door_open <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign target    = r_target;
    assign pending   = r_pending;
    assign busy      = r_busy;
    assign door_open = r_door_open;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb/tb_elevator_call_scheduler.sv - directed self-checking bench for elevator_call_scheduler
module tb_elevator_call_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] floor;
    logic [3:0] target;
    logic [3:0] pending;
    logic       busy;
    logic       door_open;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SCHED_SWEEP_EN
    localparam logic [3:0] FLIP_FIRST  = 4'b0010;
    localparam logic [3:0] FLIP_SECOND = 4'b0001;
`else
    localparam logic [3:0] FLIP_FIRST  = 4'b0001;
    localparam logic [3:0] FLIP_SECOND = 4'b0010;
`endif

    elevator_call_scheduler #(
        .DB_CYCLES    (4),
        .DWELL_CYCLES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .floor     (floor),
        .target    (target),
        .pending   (pending),
        .busy      (busy),
        .door_open (door_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] f);
        rst     = 1'b0;
        btn_raw = 4'b0000;
        floor   = f;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        do_reset(4'b0001);
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if (target !== 4'b0001 || pending !== 4'b0000 || busy !== 1'b0 || door_open !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: target=%b pending=%b busy=%b door=%b, required 0001 0000 0 0",
                         c, target, pending, busy, door_open);
            end
        end
    endtask

    task automatic test_debounce;
        do_reset(4'b0001);
        btn_raw = 4'b0100;
        tick(); tick(); tick();
        btn_raw = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if (pending !== 4'b0000) begin
                n_fail++;
                $display("FAIL bounce_ignored: pending=%b, required 0000", pending);
            end
        end
        btn_raw = 4'b0100;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 6) begin
                n_checks++;
                if (pending !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL press_early: pending=%b at cycle 6, required 0000", pending);
                end
            end
            if (k == 7) begin
                n_checks++;
                if (pending !== 4'b0100 || target !== 4'b0001 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL press_latency: pending=%b target=%b busy=%b at cycle 7, required 0100 0001 0",
                             pending, target, busy);
                end
            end
            if (k == 8) begin
                n_checks++;
                if (target !== 4'b0100 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sched_latency: target=%b busy=%b at cycle 8, required 0100 1", target, busy);
                end
            end
        end
        btn_raw = 4'b0000;
        floor   = 4'b0100;
        tick();
        n_checks++;
        if (door_open !== 1'b1 || pending !== 4'b0000) begin
            n_fail++;
            $display("FAIL arrival: door=%b pending=%b, required 1 0000", door_open, pending);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (door_open !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL dwell_hold %0d: door=%b busy=%b, required 1 1", c, door_open, busy);
            end
        end
        tick();
        n_checks++;
        if (door_open !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dwell_end: door=%b busy=%b, required 0 0", door_open, busy);
        end
    endtask

    task automatic test_two_calls_up;
        do_reset(4'b0001);
        btn_raw = 4'b1010;
        for (int c = 0; c < 7; c++) tick();
        btn_raw = 4'b0000;
        n_checks++;
        if (pending !== 4'b1010) begin
            n_fail++;
            $display("FAIL up_pending: pending=%b, required 1010", pending);
        end
        tick();
        n_checks++;
        if (target !== 4'b0010 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL up_first: target=%b busy=%b, required 0010 1", target, busy);
        end
        floor = 4'b0010;
        tick();
        n_checks++;
        if (door_open !== 1'b1 || pending !== 4'b1000) begin
            n_fail++;
            $display("FAIL up_arrive: door=%b pending=%b, required 1 1000", door_open, pending);
        end
        tick(); tick(); tick();
        n_checks++;
        if (door_open !== 1'b1 || target !== 4'b0010) begin
            n_fail++;
            $display("FAIL up_dwell_last: door=%b target=%b, required 1 0010", door_open, target);
        end
        tick();
        n_checks++;
        if (door_open !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL up_idle: door=%b busy=%b, required 0 0", door_open, busy);
        end
        tick();
        n_checks++;
        if (target !== 4'b1000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL up_second: target=%b busy=%b, required 1000 1", target, busy);
        end
        floor = 4'b1000;
        tick();
        n_checks++;
        if (door_open !== 1'b1 || pending !== 4'b0000) begin
            n_fail++;
            $display("FAIL up_arrive2: door=%b pending=%b, required 1 0000", door_open, pending);
        end
    endtask

    task automatic test_dir_flip;
        do_reset(4'b0100);
        btn_raw = 4'b0011;
        for (int c = 0; c < 7; c++) tick();
        btn_raw = 4'b0000;
        n_checks++;
        if (pending !== 4'b0011) begin
            n_fail++;
            $display("FAIL flip_pending: pending=%b, required 0011", pending);
        end
        tick();
        n_checks++;
        if (target !== FLIP_FIRST) begin
            n_fail++;
            $display("FAIL flip_first: target=%b, required %b", target, FLIP_FIRST);
        end
        floor = FLIP_FIRST;
        tick();
        n_checks++;
        if (door_open !== 1'b1 || pending !== FLIP_SECOND) begin
            n_fail++;
            $display("FAIL flip_arrive: door=%b pending=%b, required 1 %b", door_open, pending, FLIP_SECOND);
        end
        tick(); tick(); tick(); tick();
        tick();
        n_checks++;
        if (target !== FLIP_SECOND || busy !== 1'b1 || door_open !== 1'b0) begin
            n_fail++;
            $display("FAIL flip_second: target=%b busy=%b door=%b, required %b 1 0", target, busy, door_open, FLIP_SECOND);
        end
        floor = FLIP_SECOND;
        tick();
        n_checks++;
        if (pending !== 4'b0000 || door_open !== 1'b1) begin
            n_fail++;
            $display("FAIL flip_arrive2: pending=%b door=%b, required 0000 1", pending, door_open);
        end
    endtask

    task automatic test_current_floor;
        do_reset(4'b0001);
        btn_raw = 4'b0001;
        for (int c = 0; c < 7; c++) tick();
        btn_raw = 4'b0000;
        n_checks++;
        if (pending !== 4'b0001 || door_open !== 1'b0) begin
            n_fail++;
            $display("FAIL here_pending: pending=%b door=%b, required 0001 0", pending, door_open);
        end
        tick();
        n_checks++;
        if (pending !== 4'b0000 || door_open !== 1'b1 || busy !== 1'b1 || target !== 4'b0001) begin
            n_fail++;
            $display("FAIL here_reopen: pending=%b door=%b busy=%b target=%b, required 0000 1 1 0001",
                     pending, door_open, busy, target);
        end
        tick(); tick(); tick(); tick();
        n_checks++;
        if (door_open !== 1'b0 || busy !== 1'b0 || target !== 4'b0001) begin
            n_fail++;
            $display("FAIL here_done: door=%b busy=%b target=%b, required 0 0 0001", door_open, busy, target);
        end
    endtask

    task automatic test_invalid_and_reset;
        do_reset(4'b0001);
        btn_raw = 4'b0100;
        for (int c = 0; c < 7; c++) tick();
        btn_raw = 4'b0000;
        tick();
        floor = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (target !== 4'b0100 || pending !== 4'b0100 || busy !== 1'b1 || door_open !== 1'b0) begin
                n_fail++;
                $display("FAIL invalid_freeze %0d: target=%b pending=%b busy=%b door=%b, required 0100 0100 1 0",
                         c, target, pending, busy, door_open);
            end
        end
        floor = 4'b0100;
        tick();
        tick();
        n_checks++;
        if (door_open !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_dwell: door=%b, required 1", door_open);
        end
        #2;
        btn_raw = 4'b1000;
        rst     = 1'b0;
        #1;
        n_checks++;
        if (target !== 4'b0001 || pending !== 4'b0000 || busy !== 1'b0 || door_open !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: target=%b pending=%b busy=%b door=%b, required 0001 0000 0 0",
                     target, pending, busy, door_open);
        end
        @(negedge clk);
        tick();
        rst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) begin
                n_checks++;
                if (pending !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL held_early: pending=%b, required 0000", pending);
                end
            end
            if (k == 7) begin
                n_checks++;
                if (pending !== 4'b1000) begin
                    n_fail++;
                    $display("FAIL held_repress: pending=%b, required 1000", pending);
                end
            end
        end
        btn_raw = 4'b0000;
    endtask

    initial begin
        rst     = 1'b0;
        btn_raw = 4'b0000;
        floor   = 4'b0001;
        test_reset();
        test_debounce();
        test_two_calls_up();
        test_dir_flip();
        test_current_floor();
        test_invalid_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
